bram_dump: RTL
==============

BRAM_DUMP -- requirements
Module: bram_dump

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 10, byte-address width of the BRAM debug port.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, BRAM word width.
REQ-003 SHALL provide port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL provide port base_addr  input  ADDR_WIDTH  byte address of the first word to dump.
REQ-007 SHALL provide port word_count  input  ADDR_WIDTH-1  number of words to dump; 0 means none.
REQ-008 SHALL provide port debug_addr  output  ADDR_WIDTH  byte address driven to the BRAM debug read port.
REQ-009 SHALL provide port debug_data  input  DATA_WIDTH  BRAM debug read data, valid one cycle after debug_addr.
REQ-010 SHALL provide port out_valid  output  1  out_data/out_addr hold a word for the consumer.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts the word this cycle.
REQ-012 SHALL provide port out_data  output  DATA_WIDTH  dumped word.
REQ-013 SHALL provide port out_addr  output  ADDR_WIDTH  byte address of out_data.
REQ-014 SHALL provide port busy  output  1  dump in progress; the integration ties it to pc stall.
REQ-015 SHALL provide port done  output  1  one-cycle pulse when a dump completes.
REQ-016 SHALL provide port err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, CAPTURE, SEND, and FINISH.
REQ-018 In IDLE with start=1: if base_addr[1:0]!=0, SHALL pulse err next cycle, stay IDLE, and emit no word.
REQ-019 In IDLE with start=1, aligned, word_count=0: SHALL go to FINISH, so done pulses the cycle after start and no out_valid occurs.
REQ-020 In IDLE with start=1, aligned, word_count>0: SHALL latch base_addr into the address counter and word_count into the remaining counter, then go to ISSUE.
REQ-021 In ISSUE, debug_addr SHALL equal the address counter, and the next state SHALL be CAPTURE.
REQ-022 In CAPTURE, SHALL register debug_data into out_data and the address counter into out_addr, then go to SEND.
REQ-023 In SEND, out_valid SHALL be 1, with out_data/out_addr held stable until out_ready=1.
REQ-024 On the SEND handshake (out_valid & out_ready), SHALL add 4 to the address counter modulo 2^ADDR_WIDTH and decrement remaining.
REQ-025 After the SEND handshake, SHALL go to ISSUE if remaining (after decrement) >0, else to FINISH.
REQ-026 Latency: out_valid SHALL first assert 3 cycles after the edge that samples start; throughput SHALL be 1 word per 3 cycles when out_ready=1.
REQ-027 FINISH SHALL assert done for exactly one cycle, then go to IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start asserted while busy=1 SHALL be ignored, with no err and no change to the counters.
REQ-030 Address wrap: a dump crossing the top of memory SHALL continue from address 0.
REQ-031 out_valid SHALL never deassert without a handshake, and out_data SHALL not change while out_valid=1 and out_ready=0.
REQ-032 debug_addr SHALL hold its last value outside ISSUE.

Reset
REQ-033 When rst=0, SHALL asynchronously force state IDLE and drive busy=0, done=0, err=0, out_valid=0, out_data=0, out_addr=0, debug_addr=0, and both counters to 0.
REQ-034 Reset asserted mid-dump SHALL abort the dump, with no done pulse and no further out_valid.
REQ-035 After rst returns to 1, the first start SHALL be honoured on the next rising edge.

Verification
REQ-036 BRAM words 0x0=00000001, 0x4=00000002, 0x8=00000003; start with base=0x0, count=3, out_ready=1 -> addresses 0x0/0x4/0x8 with data 1/2/3; first out_valid 3 cycles after start; done one cycle after the 3rd handshake.
REQ-037 Same setup with out_ready held 0 for 5 cycles during word 2 -> out_valid stays 1 and out_data stays 00000002 throughout; no word is lost or duplicated.
REQ-038 start with base=0x3FC, count=2 -> out_addr 0x3FC then 0x000.
REQ-039 start with base=0x6 -> err pulse, busy stays 0, no out_valid; start with count=0 -> done pulse the next cycle, no out_valid.
REQ-040 rst driven to 0 mid-SEND with count=3 -> all outputs 0 immediately, no done; a later start with base=0x4, count=1 -> a single word 00000002.
REQ-041 Second start during a dump -> ignored; exactly the original count of words is emitted.

Source files
------------

// File: rtl/bram_dump_if.sv
// Output word stream from the BRAM dumper: valid/ready handshake carrying data and its byte address.
// Master drives valid/data/addr; slave drives ready.
interface bram_dump_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        output out_ready
    );
endinterface

// File: rtl/bram_dump.sv
// Walks a BRAM debug read port from base_addr and streams word_count words with their byte addresses.
// Latency: first out_valid 3 cycles after start; then one word per 3 cycles.
// Backpressure: SEND holds out_valid/out_data/out_addr until out_ready; nothing advances meanwhile.
module bram_dump #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-2:0] word_count,
    output logic [ADDR_WIDTH-1:0] debug_addr,
    input  logic [DATA_WIDTH-1:0] debug_data,
    bram_dump_if.master           out_if,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
    localparam logic [CW-1:0]         LAST_WORD = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        SEND,
        FINISH
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         rem_q;
    logic                  err_q;
    logic                  send_hs;

    assign send_hs = (state_q == SEND) && out_if.out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && (base_addr[1:0] == 2'b00)) begin
                    state_d = (word_count == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = SEND;
            SEND: begin
                if (out_if.out_ready) begin
                    state_d = (rem_q == LAST_WORD) ? FINISH : ISSUE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // debug_addr is loaded on the edge entering ISSUE so it matches addr_q there and holds elsewhere.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q          <= '0;
            rem_q           <= '0;
            err_q           <= 1'b0;
            debug_addr      <= '0;
            out_if.out_data <= '0;
            out_if.out_addr <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (base_addr[1:0] != 2'b00) begin
                            err_q <= 1'b1;
                        end else if (word_count != '0) begin
                            addr_q     <= base_addr;
                            rem_q      <= word_count;
                            debug_addr <= base_addr;
                        end
                    end
                end
                CAPTURE: begin
                    out_if.out_data <= debug_data;
                    out_if.out_addr <= addr_q;
                end
                SEND: begin
                    if (send_hs) begin
                        addr_q <= addr_q + WORD_STEP;
                        rem_q  <= rem_q - LAST_WORD;
                        if (rem_q != LAST_WORD) begin
                            debug_addr <= addr_q + WORD_STEP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_if.out_valid = (state_q == SEND);
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == FINISH);
    assign err              = err_q;

endmodule
